btpipe_out_buffer: RTL



---
 rtl/btpipe_out_buffer_if.sv | 20 ++
 rtl/btpipe_out_buffer.sv | 116 +++++++++++
 2 files changed

// File: rtl/btpipe_out_buffer_if.sv
// Producer stream and host pipe-out endpoint signals of the block-throttled out buffer.
// master = producer/endpoint side, slave = buffer side.
interface btpipe_out_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        pipe_out_read;
    logic [15:0] pipe_out_data;
    logic        pipe_out_valid;

    modport master (
        output in_valid, in_data, pipe_out_read,
        input  in_ready, pipe_out_data, pipe_out_valid
    );

    modport slave (
        input  in_valid, in_data, pipe_out_read,
        output in_ready, pipe_out_data, pipe_out_valid
    );
endinterface

// File: rtl/btpipe_out_buffer.sv
// Block-throttled pipe-out source buffer: FIFO between a producer stream and the host
// pipe-out endpoint, advertising ready only once a full block is stored.
module btpipe_out_buffer #(
    parameter int BLOCK_WORDS = 256,
    parameter int DEPTH_LOG2  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    btpipe_out_buffer_if.slave    bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic [15:0]           underflow_count
);
    // state | meaning
    // IDLE  | waiting for level >= BLOCK_WORDS, pipe_out_valid low
    // READY | a full block is stored, pipe_out_valid high
    // BURST | host is reading the block, counting down remaining words
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int                   CNT_W       = $clog2(BLOCK_WORDS + 1);
    localparam logic [DEPTH_LOG2:0]  BLOCK_LEVEL = (DEPTH_LOG2 + 1)'(BLOCK_WORDS);
    localparam logic [CNT_W-1:0]     CNT_LOAD    = CNT_W'(BLOCK_WORDS - 1);

    logic [15:0]          mem [0:(1 << DEPTH_LOG2) - 1];
    logic [15:0]          ram_q;
    logic [DEPTH_LOG2:0]  wr_ptr;
    logic [DEPTH_LOG2:0]  rd_ptr;
    logic                 init_done;
    logic                 zero_q;
    logic                 valid_q;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [CNT_W-1:0]     blk_cnt;
    state_t               state;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level = wr_ptr - rd_ptr;

    assign bus.in_ready       = init_done && !full;
    assign push               = bus.in_valid && bus.in_ready && !flush;
    assign pop                = bus.pipe_out_read && !empty && !flush;
    assign bus.pipe_out_valid = valid_q;
    // Underflow reads and reset present zero without touching the RAM output register.
    assign bus.pipe_out_data  = zero_q ? 16'h0000 : ram_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.in_data;
        if (pop)  ram_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            init_done       <= 1'b0;
            zero_q          <= 1'b1;
            valid_q         <= 1'b0;
            underflow_count <= '0;
            blk_cnt         <= '0;
            state           <= IDLE;
        end else begin
            init_done <= 1'b1;
            if (flush) begin
                wr_ptr          <= '0;
                rd_ptr          <= '0;
                valid_q         <= 1'b0;
                underflow_count <= '0;
                blk_cnt         <= '0;
                state           <= IDLE;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    zero_q <= 1'b0;
                end else if (bus.pipe_out_read) begin
                    zero_q <= 1'b1;
                    if (underflow_count != 16'hFFFF) underflow_count <= underflow_count + 16'd1;
                end

                case (state)
                    IDLE: begin
                        if (level >= BLOCK_LEVEL) begin
                            state   <= READY;
                            valid_q <= 1'b1;
                        end
                    end
                    READY: begin
                        if (bus.pipe_out_read) begin
                            valid_q <= 1'b0;
                            blk_cnt <= CNT_LOAD;
                            state   <= (CNT_LOAD == '0) ? IDLE : BURST;
                        end
                    end
                    BURST: begin
                        if (bus.pipe_out_read) begin
                            blk_cnt <= blk_cnt - CNT_W'(1);
                            if (blk_cnt == CNT_W'(1)) state <= IDLE;
                        end
                    end
                    default: begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule
